// File: rtl/alu_issue_unit_pkg.sv
// Shared CPU definitions for the ALU issue unit: sequencer states, register
// selects, ALU operation codes, flag bit positions and the opcode legality test.
package alu_issue_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPERAND = 2'd1,
    ST_EXEC    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    REG_B   = 3'd0,
    REG_C   = 3'd1,
    REG_D   = 3'd2,
    REG_E   = 3'd3,
    REG_H   = 3'd4,
    REG_L   = 3'd5,
    REG_HLI = 3'd6,
    REG_A   = 3'd7
  } reg_sel_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_OR  = 3'd6,
    ALU_CP  = 3'd7
  } alu_op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  // 0x80-0xBF register/(HL) forms, or 0xC6..0xFE immediate forms.
  function automatic logic is_alu_opcode(input logic [7:0] op);
    return (op[7:6] == 2'b10) || ((op[7:6] == 2'b11) && (op[2:0] == REG_HLI));
  endfunction

endpackage

// File: rtl/alu_issue_unit.sv
// Sequences one ALU-class instruction: fetch operand (register file, (HL) or
// immediate byte), present it to the external ALU, write back A and F.
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic [7:0]        i_Opcode,
  input  logic [ADDR_W-1:0] i_HL,
  input  logic [ADDR_W-1:0] i_PC,
  output logic [2:0]        o_Reg_Sel,
  input  logic [7:0]        i_Reg_Data,
  output logic              o_Mem_Req,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  input  logic              i_Mem_Ack,
  input  logic [7:0]        i_Mem_Data,
  output logic              o_PC_Inc,
  output logic [7:0]        o_ALU_A,
  output logic [7:0]        o_ALU_B,
  output logic [2:0]        o_ALU_Op,
  output logic [3:0]        o_ALU_F,
  input  logic [7:0]        i_ALU_Result,
  input  logic [3:0]        i_ALU_F,
  input  logic              i_A_We,
  input  logic [7:0]        i_A_Wdata,
  input  logic              i_F_We,
  input  logic [3:0]        i_F_Wdata,
  output logic [7:0]        o_A,
  output logic [7:0]        o_F,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Illegal
);

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] a_q, a_d;
  logic [3:0] f_q, f_d;
  logic       done_q, done_d;
  logic       illegal_q, illegal_d;
  logic       pc_inc_q, pc_inc_d;

  logic mem_form;
  logic imm_form;

  assign mem_form = (op_q[2:0] == REG_HLI);
  assign imm_form = (op_q[7:6] == 2'b11);

  // NOTE: every flop resets asynchronously so an abort mid-operation leaves no
  // partial writeback; non-blocking assignments keep all flops updating together.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      op_q      <= 8'h00;
      operand_q <= 8'h00;
      a_q       <= 8'h00;
      f_q       <= 4'h0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      pc_inc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      a_q       <= a_d;
      f_q       <= f_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      pc_inc_q  <= pc_inc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (i_Start && is_alu_opcode(i_Opcode)) state_d = ST_OPERAND;
      ST_OPERAND: if (!mem_form || i_Mem_Ack) state_d = ST_EXEC;
      ST_EXEC:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: each signal gets a default before the case so no latch is inferred.
  always_comb begin
    op_d      = op_q;
    operand_d = operand_q;
    a_d       = a_q;
    f_d       = f_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    pc_inc_d  = 1'b0;

    if (i_A_We) a_d = i_A_Wdata;
    if (i_F_We) f_d = i_F_Wdata;

    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          if (is_alu_opcode(i_Opcode)) op_d = i_Opcode;
          else                         illegal_d = 1'b1;
        end
      end
      ST_OPERAND: begin
        if (!mem_form) begin
          operand_d = (op_q[2:0] == REG_A) ? a_q : i_Reg_Data;
        end else if (i_Mem_Ack) begin
          operand_d = i_Mem_Data;
          pc_inc_d  = imm_form;
        end
      end
      ST_EXEC: begin
        // Writeback comes after the external writes so it takes priority.
        f_d = i_ALU_F;
        if (op_q[5:3] != ALU_CP) a_d = i_ALU_Result;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_Busy     = (state_q != ST_IDLE);
    o_Reg_Sel  = op_q[2:0];
    o_Mem_Req  = (state_q == ST_OPERAND) && mem_form;
    o_Mem_Addr = imm_form ? i_PC : i_HL;
    o_ALU_A    = a_q;
    o_ALU_B    = operand_q;
    o_ALU_Op   = op_q[5:3];
    o_ALU_F    = f_q;
  end

  assign o_A       = a_q;
  assign o_F       = {f_q[FLAG_Z], f_q[FLAG_N], f_q[FLAG_H], f_q[FLAG_C], 4'h0};
  assign o_Done    = done_q;
  assign o_Illegal = illegal_q;
  assign o_PC_Inc  = pc_inc_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural 8-bit ALU on the side.
module tb_alu_issue_unit;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        i_Start;
  logic [7:0]  i_Opcode;
  logic [15:0] i_HL;
  logic [15:0] i_PC;
  logic [2:0]  o_Reg_Sel;
  logic [7:0]  i_Reg_Data;
  logic        o_Mem_Req;
  logic [15:0] o_Mem_Addr;
  logic        i_Mem_Ack;
  logic [7:0]  i_Mem_Data;
  logic        o_PC_Inc;
  logic [7:0]  o_ALU_A;
  logic [7:0]  o_ALU_B;
  logic [2:0]  o_ALU_Op;
  logic [3:0]  o_ALU_F;
  logic [7:0]  i_ALU_Result;
  logic [3:0]  i_ALU_F;
  logic        i_A_We;
  logic [7:0]  i_A_Wdata;
  logic        i_F_We;
  logic [3:0]  i_F_Wdata;
  logic [7:0]  o_A;
  logic [7:0]  o_F;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Illegal;

  int total = 0;
  int bad   = 0;

  alu_issue_unit #(.ADDR_W(16)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Opcode(i_Opcode),
    .i_HL(i_HL), .i_PC(i_PC), .o_Reg_Sel(o_Reg_Sel), .i_Reg_Data(i_Reg_Data),
    .o_Mem_Req(o_Mem_Req), .o_Mem_Addr(o_Mem_Addr), .i_Mem_Ack(i_Mem_Ack),
    .i_Mem_Data(i_Mem_Data), .o_PC_Inc(o_PC_Inc), .o_ALU_A(o_ALU_A),
    .o_ALU_B(o_ALU_B), .o_ALU_Op(o_ALU_Op), .o_ALU_F(o_ALU_F),
    .i_ALU_Result(i_ALU_Result), .i_ALU_F(i_ALU_F), .i_A_We(i_A_We),
    .i_A_Wdata(i_A_Wdata), .i_F_We(i_F_We), .i_F_Wdata(i_F_Wdata),
    .o_A(o_A), .o_F(o_F), .o_Busy(o_Busy), .o_Done(o_Done), .o_Illegal(o_Illegal)
  );

  always #5 i_Clk = ~i_Clk;

  // Reference ALU; result and flags {Z,N,H,C}.
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op, input logic [3:0] f);
    logic       cin;
    logic [8:0] r;
    logic [4:0] h;
    logic [3:0] nf;
    cin = ((op == 3'd1) || (op == 3'd3)) ? f[0] : 1'b0;
    r   = 9'd0;
    h   = 5'd0;
    nf  = 4'd0;
    case (op)
      3'd0, 3'd1: begin
        r  = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        h  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
        nf = {(r[7:0] == 8'd0), 1'b0, h[4], r[8]};
      end
      3'd2, 3'd3, 3'd7: begin
        r  = {1'b0, a} - {1'b0, b} - {8'd0, cin};
        h  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, cin};
        nf = {(r[7:0] == 8'd0), 1'b1, h[4], r[8]};
      end
      3'd4: begin
        r  = {1'b0, a & b};
        nf = {(r[7:0] == 8'd0), 1'b0, 1'b1, 1'b0};
      end
      3'd5: begin
        r  = {1'b0, a ^ b};
        nf = {(r[7:0] == 8'd0), 3'b000};
      end
      default: begin
        r  = {1'b0, a | b};
        nf = {(r[7:0] == 8'd0), 3'b000};
      end
    endcase
    return {r[7:0], nf};
  endfunction

  assign {i_ALU_Result, i_ALU_F} = alu_model(o_ALU_A, o_ALU_B, o_ALU_Op, o_ALU_F);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_Clk);
  endtask

  initial begin
    i_Rst = 1'b1; i_Start = 1'b0; i_Opcode = 8'h00; i_HL = 16'h0000; i_PC = 16'h0000;
    i_Reg_Data = 8'h00; i_Mem_Ack = 1'b0; i_Mem_Data = 8'h00;
    i_A_We = 1'b0; i_A_Wdata = 8'h00; i_F_We = 1'b0; i_F_Wdata = 4'h0;
    repeat (2) tick();
    check("rst_a", o_A, 8'h00);
    check("rst_f", o_F, 8'h00);
    check("rst_busy", o_Busy, 1'b0);
    check("rst_req", o_Mem_Req, 1'b0);
    check("rst_done", o_Done, 1'b0);
    i_Rst = 1'b0;

    // ADD A,B : 0x3A + 0xC6
    i_A_We = 1'b1; i_A_Wdata = 8'h3A; tick(); i_A_We = 1'b0;
    check("ext_a_write", o_A, 8'h3A);
    i_Reg_Data = 8'hC6; i_Opcode = 8'h80; i_Start = 1'b1; tick(); i_Start = 1'b0;
    check("add_busy", o_Busy, 1'b1);
    check("add_sel", o_Reg_Sel, 3'd0);
    check("add_done_early", o_Done, 1'b0);
    tick();
    check("add_alu_a", o_ALU_A, 8'h3A);
    check("add_alu_b", o_ALU_B, 8'hC6);
    check("add_done_exec", o_Done, 1'b0);
    tick();
    check("add_done", o_Done, 1'b1);
    check("add_a", o_A, 8'h00);
    check("add_f", o_F, 8'hB0);
    check("add_idle", o_Busy, 1'b0);
    tick();
    check("add_done_pulse", o_Done, 1'b0);

    // ADC A,E with carry in
    i_A_We = 1'b1; i_A_Wdata = 8'hE1; i_F_We = 1'b1; i_F_Wdata = 4'b0001; tick();
    i_A_We = 1'b0; i_F_We = 1'b0;
    check("ext_f_write", o_F, 8'h10);
    i_Reg_Data = 8'h0F; i_Opcode = 8'h8B; i_Start = 1'b1; tick(); i_Start = 1'b0;
    check("adc_sel", o_Reg_Sel, 3'd3);
    tick(); tick();
    check("adc_done", o_Done, 1'b1);
    check("adc_a", o_A, 8'hF1);
    check("adc_f", o_F, 8'h20);

    // CP 0x40 (immediate), ack in the first operand cycle
    i_A_We = 1'b1; i_A_Wdata = 8'h3C; tick(); i_A_We = 1'b0;
    i_PC = 16'h0150; i_Opcode = 8'hFE; i_Start = 1'b1; tick(); i_Start = 1'b0;
    check("cp_req", o_Mem_Req, 1'b1);
    check("cp_addr", o_Mem_Addr, 16'h0150);
    check("cp_pcinc_early", o_PC_Inc, 1'b0);
    i_Mem_Ack = 1'b1; i_Mem_Data = 8'h40; tick(); i_Mem_Ack = 1'b0;
    check("cp_pcinc", o_PC_Inc, 1'b1);
    check("cp_req_drop", o_Mem_Req, 1'b0);
    tick();
    check("cp_pcinc_pulse", o_PC_Inc, 1'b0);
    check("cp_done", o_Done, 1'b1);
    check("cp_a", o_A, 8'h3C);
    check("cp_f", o_F, 8'h50);

    // SUB (HL) with three wait cycles and an ignored i_Start
    i_A_We = 1'b1; i_A_Wdata = 8'h3E; tick(); i_A_We = 1'b0;
    i_HL = 16'hC000; i_Opcode = 8'h96; i_Start = 1'b1; tick(); i_Start = 1'b0;
    check("sub_req1", o_Mem_Req, 1'b1);
    check("sub_addr", o_Mem_Addr, 16'hC000);
    tick();
    check("sub_req2", o_Mem_Req, 1'b1);
    i_Opcode = 8'h00; i_Start = 1'b1; tick(); i_Start = 1'b0;
    check("sub_req3", o_Mem_Req, 1'b1);
    check("sub_busy_start_ignored", o_Illegal, 1'b0);
    tick();
    check("sub_req4", o_Mem_Req, 1'b1);
    i_Mem_Ack = 1'b1; i_Mem_Data = 8'h3E; tick(); i_Mem_Ack = 1'b0;
    check("sub_req_drop", o_Mem_Req, 1'b0);
    check("sub_no_pcinc", o_PC_Inc, 1'b0);
    check("sub_done_exec", o_Done, 1'b0);
    tick();
    check("sub_done", o_Done, 1'b1);
    check("sub_a", o_A, 8'h00);
    check("sub_f", o_F, 8'hC0);

    // AND A,A: register data ignored, EXEC beats external writes
    i_A_We = 1'b1; i_A_Wdata = 8'h5A; tick(); i_A_We = 1'b0;
    i_Reg_Data = 8'hFF; i_Opcode = 8'hA7; i_Start = 1'b1; tick(); i_Start = 1'b0;
    check("and_sel", o_Reg_Sel, 3'd7);
    tick();
    check("and_alu_b", o_ALU_B, 8'h5A);
    i_A_We = 1'b1; i_A_Wdata = 8'h99; i_F_We = 1'b1; i_F_Wdata = 4'hF; tick();
    i_A_We = 1'b0; i_F_We = 1'b0;
    check("and_done", o_Done, 1'b1);
    check("and_a", o_A, 8'h5A);
    check("and_f", o_F, 8'h20);
    i_Opcode = 8'h00; i_Start = 1'b1; tick(); i_Start = 1'b0;
    check("illegal_pulse", o_Illegal, 1'b1);
    check("illegal_idle", o_Busy, 1'b0);
    tick();
    check("illegal_clear", o_Illegal, 1'b0);
    check("illegal_a", o_A, 8'h5A);
    check("illegal_f", o_F, 8'h20);

    // Reset while waiting for the (HL) ack
    i_Opcode = 8'h96; i_Start = 1'b1; tick(); i_Start = 1'b0;
    check("abort_req", o_Mem_Req, 1'b1);
    tick();
    i_Rst = 1'b1; #1;
    check("abort_req_drop", o_Mem_Req, 1'b0);
    check("abort_a", o_A, 8'h00);
    check("abort_f", o_F, 8'h00);
    check("abort_busy", o_Busy, 1'b0);
    tick(); tick();
    check("abort_no_done", o_Done, 1'b0);
    i_Rst = 1'b0; tick();
    check("abort_no_done_after", o_Done, 1'b0);
    check("abort_idle_after", o_Busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequencer and initiator for the combinational 8-bit ALU.
- Accepts a decoded ALU-class opcode (0x80–0xBF register/(HL) forms; 0xC6/CE/D6/DE/E6/EE/F6/FE immediate forms).
- Fetches the operand from the register file or the memory bus, drives the ALU, then writes the result back.
- Owns the accumulator A and flag register F. Sits between the instruction decoder and the ALU.

Parameters:
- ADDR_W, 16, memory address width.

Ports:
- i_Clk  in  1  clock. One clock domain; reset is asynchronous and active-high.
- i_Rst  in  1  asynchronous active-high reset.
- i_Start  in  1  one-cycle request; i_Opcode valid with it.
- i_Opcode  in  8  full instruction opcode.
- i_HL  in  16  current HL register value.
- i_PC  in  16  current PC; address of the immediate byte.
- o_Reg_Sel  out  3  register-file read select (0=B,1=C,2=D,3=E,4=H,5=L,7=A).
- i_Reg_Data  in  8  combinational register-file read data.
- o_Mem_Req  out  1  memory read request.
- o_Mem_Addr  out  ADDR_W  read address.
- i_Mem_Ack  in  1  read data valid; completes the request.
- i_Mem_Data  in  8  read data.
- o_PC_Inc  out  1  one-cycle pulse: immediate byte consumed.
- o_ALU_A  out  8  ALU accumulator input.
- o_ALU_B  out  8  ALU second operand.
- o_ALU_Op  out  3  ALU operation (opcode bits 5:3).
- o_ALU_F  out  4  ALU old flags {Z,N,H,C}.
- i_ALU_Result  in  8  ALU result.
- i_ALU_F  in  4  ALU new flags.
- i_A_We  in  1  external A write (loads).
- i_A_Wdata  in  8  external A data.
- i_F_We  in  1  external F write.
- i_F_Wdata  in  4  external flag data {Z,N,H,C}.
- o_A  out  8  accumulator.
- o_F  out  8  flags; bits 3:0 always 0.
- o_Busy  out  1  state != IDLE.
- o_Done  out  1  one-cycle pulse after writeback.
- o_Illegal  out  1  one-cycle pulse: non-ALU opcode on i_Start.

Behaviour:
- Reset (async): state IDLE. o_A=0x00, o_F=0x00. All pulses and o_Mem_Req are 0. Reset mid-operation aborts immediately; no writeback occurs.
- States:
  - IDLE: i_Start with a legal opcode latches the opcode and goes to OPERAND. i_Start with an illegal opcode raises o_Illegal the next cycle and stays in IDLE.
  - OPERAND, register form (op[7:6]=10, op[2:0]≠6): o_Reg_Sel=op[2:0]. Latch i_Reg_Data, or internal A when sel=7 (i_Reg_Data ignored). Go to EXEC after one cycle.
  - OPERAND, memory form ((HL) or immediate): o_Mem_Req=1 combinationally from state. o_Mem_Addr=i_HL or i_PC. Hold request until i_Mem_Ack; latch i_Mem_Data on the ack edge and go to EXEC. Ack in the first OPERAND cycle is legal. Immediate form: o_PC_Inc pulses the cycle after the ack edge.
  - EXEC: drive ALU inputs (o_ALU_A=o_A, o_ALU_B=operand, o_ALU_Op=op[5:3], o_ALU_F=o_F[7:4]). On the edge:
    - F <= i_ALU_F.
    - A <= i_ALU_Result, unless op[5:3]=7 (CP, A unchanged).
    - o_Done=1 the next cycle; go to IDLE.
- ALU outputs are used only in EXEC; ALU inputs are don't-care otherwise. o_ALU_* hold last values.
- Latency: register form, i_Start edge to o_Done high = 2 cycles. Memory form = 2 + ack wait cycles.
- i_Start while o_Busy: ignored, no o_Illegal.
- External writes: i_A_We/i_F_We take effect in any state. If EXEC writes the same register in the same cycle, EXEC wins. o_F[3:0] is forced to 0.
- Back-to-back: i_Start in the o_Done cycle is accepted, since the state is IDLE.

Decomposition:
- Shared CPU package holds:
  - state encoding (IDLE, OPERAND, EXEC);
  - register-select constants REG_B..REG_A, REG_HLI=6;
  - ALU op constants ADD..CP;
  - flag bit indices Z=3, N=2, H=1, C=0.
- No sub-module; the ALU is instantiated alongside this block by the CPU top level.

Test Plan:
- A=0x3A, B=0xC6, opcode 0x80 (ADD A,B) -> o_Reg_Sel=0. After 2 cycles o_Done=1, o_A=0x00, o_F=0xB0.
- F=0x10, A=0xE1, E=0x0F, opcode 0x8B (ADC A,E) -> o_A=0xF1, o_F=0x20.
- A=0x3C, opcode 0xFE, PC=0x0150, mem[0x0150]=0x40 -> o_Mem_Addr=0x0150, one o_PC_Inc pulse. o_A stays 0x3C, o_F=0x50.
- A=0x3E, opcode 0x96 (SUB (HL)), HL=0xC000, ack delayed 3 cycles, data 0x3E -> o_Mem_Req held 4 cycles, o_A=0x00, o_F=0xC0. i_Start pulsed mid-wait is ignored.
- A=0x5A, opcode 0xA7, i_Reg_Data=0xFF -> o_A=0x5A, o_F=0x20. Opcode 0x00 -> o_Illegal pulse, A/F unchanged.
- Assert i_Rst while waiting for ack in a SUB (HL) -> o_Mem_Req drops immediately, o_A=0x00, o_F=0x00, no o_Done.
